// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the multi-channel push-button debouncer.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PEND_H   = 3'd1,
        HELD_DLY = 3'd2,
        HELD_RPT = 3'd3,
        PEND_L   = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One shared counter covers both the stability window and the repeat timers.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

    function automatic bit params_legal(input int num_ch, input int sync_stages,
                                        input int stable_cnt, input int repeat_delay,
                                        input int repeat_rate);
        return (num_ch >= 1) && (sync_stages >= 2) && (stable_cnt >= 1) &&
               (repeat_delay >= 2) && (repeat_rate >= 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability-qualifying FSM and hold-to-repeat timer.
// The release pulse is named rel because release is a reserved word.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 95,
    parameter int REPEAT_RATE  = 19
) (
    input  logic Clk190,
    input  logic Reset_n,
    input  logic din,
    input  logic rep_en,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(STABLE_CNT, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST   = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, held_last;
    logic                   level_nxt, press_nxt, rel_nxt;

    always_ff @(posedge Clk190 or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync[SYNC_STAGES-1];

    always_ff @(posedge Clk190 or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // A single-cycle stability window skips the pending states entirely.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        held_last = (state == HELD_RPT) ? RATE_LAST : DELAY_LAST;
        case (state)
            IDLE: begin
                if (sync_q) begin
                    if (STABLE_CNT == 1) begin
                        state_nxt = HELD_DLY;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        state_nxt = PEND_H;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            PEND_H: begin
                if (!sync_q) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = HELD_DLY;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD_DLY, HELD_RPT: begin
                if (!sync_q) begin
                    if (STABLE_CNT == 1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                    end else begin
                        state_nxt = PEND_L;
                        cnt_nxt   = CNT_ONE;
                    end
                end else if (!rep_en) begin
                    state_nxt = HELD_DLY;
                    cnt_nxt   = '0;
                end else if (cnt == held_last) begin
                    state_nxt = HELD_RPT;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PEND_L: begin
                if (sync_q) begin
                    state_nxt = HELD_DLY;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_channel_debouncer.sv
// N independent debounce channels behind one reset-release flop; rep_en is shared by all channels.
// The release pulses are exported on rel because release is a reserved word.
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 95,
    parameter int REPEAT_RATE  = 19
) (
    input  logic              Clk190,
    input  logic              Reset_n,
    input  logic [NUM_CH-1:0] din,
    input  logic              rep_en,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] rel
);

    if (!params_legal(NUM_CH, SYNC_STAGES, STABLE_CNT, REPEAT_DELAY, REPEAT_RATE)) begin : g_param_check
        $error("multi_channel_debouncer: illegal parameter set");
    end

    logic reset_q;

    // Assert asynchronously, let the channels out of reset only on a clock edge.
    always_ff @(posedge Clk190 or negedge Reset_n) begin
        if (!Reset_n) begin
            reset_q <= 1'b0;
        end else begin
            reset_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .Clk190 (Clk190),
            .Reset_n(reset_q),
            .din    (din[i]),
            .rep_en (rep_en),
            .level  (level[i]),
            .press  (press[i]),
            .rel    (rel[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Self-checking bench: directed scenarios plus random bouncing buttons, compared every cycle
// against a run-length / elapsed-time reference model of the debouncer.
module tb_multi_channel_debouncer;

    localparam int NUM_CH       = 5;
    localparam int SYNC_STAGES  = 2;
    localparam int STABLE_CNT   = 4;
    localparam int REPEAT_DELAY = 95;
    localparam int REPEAT_RATE  = 19;
    localparam int LATENCY      = SYNC_STAGES + STABLE_CNT - 1;

    logic              Clk190  = 1'b0;
    logic              Reset_n = 1'b1;
    logic [NUM_CH-1:0] din     = '0;
    logic              rep_en  = 1'b0;
    logic [NUM_CH-1:0] level, press, rel;

    int checkCount = 0;
    int failCount  = 0;
    int cycle      = 0;

    logic [NUM_CH-1:0] mLevel, expPress, expRel;
    logic              mResetQ;
    logic              mPipe [NUM_CH][SYNC_STAGES];
    int                mRun [NUM_CH];
    int                mElapsed [NUM_CH];
    bit                mRate [NUM_CH];

    int phaseEdge;
    int pressSeen [NUM_CH];
    int relSeen [NUM_CH];
    int firstPress [NUM_CH];
    int allPress, allRel;

    logic [NUM_CH-1:0] target, rd;
    int                bounceLeft [NUM_CH];
    logic              rr;

    multi_channel_debouncer #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .Clk190 (Clk190),
        .Reset_n(Reset_n),
        .din    (din),
        .rep_en (rep_en),
        .level  (level),
        .press  (press),
        .rel    (rel)
    );

    always #5 Clk190 = ~Clk190;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic modelReset();
        mLevel   = '0;
        expPress = '0;
        expRel   = '0;
        mResetQ  = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int k = 0; k < SYNC_STAGES; k++) mPipe[ch][k] = 1'b0;
            mRun[ch]     = 0;
            mElapsed[ch] = 0;
            mRate[ch]    = 1'b0;
        end
    endtask

    // Level flips after STABLE_CNT consecutive disagreeing samples; repeats count held, agreeing cycles.
    task automatic modelStep(input logic [NUM_CH-1:0] d, input logic r, input logic rn);
        logic s;
        expPress = '0;
        expRel   = '0;
        if (!rn) begin
            modelReset();
            return;
        end
        if (!mResetQ) begin
            mResetQ = 1'b1;
            return;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            s = mPipe[ch][SYNC_STAGES-1];
            for (int k = SYNC_STAGES - 1; k > 0; k--) mPipe[ch][k] = mPipe[ch][k-1];
            mPipe[ch][0] = d[ch];
            if (s != mLevel[ch]) begin
                mRun[ch]++;
                if (mRun[ch] == STABLE_CNT) begin
                    mLevel[ch]   = s;
                    mRun[ch]     = 0;
                    mElapsed[ch] = 0;
                    mRate[ch]    = 1'b0;
                    if (s) expPress[ch] = 1'b1;
                    else   expRel[ch]   = 1'b1;
                end
            end else if (mLevel[ch]) begin
                if (mRun[ch] != 0 || !r) begin
                    mElapsed[ch] = 0;
                    mRate[ch]    = 1'b0;
                end else begin
                    mElapsed[ch]++;
                    if (mElapsed[ch] == (mRate[ch] ? REPEAT_RATE : REPEAT_DELAY)) begin
                        expPress[ch] = 1'b1;
                        mElapsed[ch] = 0;
                        mRate[ch]    = 1'b1;
                    end
                end
                mRun[ch] = 0;
            end else begin
                mRun[ch] = 0;
            end
        end
    endtask

    task automatic clearStats();
        phaseEdge = 0;
        allPress  = 0;
        allRel    = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pressSeen[ch]  = 0;
            relSeen[ch]    = 0;
            firstPress[ch] = -1;
        end
    endtask

    // Drive one input pattern for n cycles; outputs are checked 1 ns after each rising edge.
    task automatic applyStimulus(input logic [NUM_CH-1:0] d, input logic r, input logic rn, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk190);
            din    = d;
            rep_en = r;
            if (!rn && Reset_n) begin
                Reset_n = 1'b0;
                #1;
                modelReset();
                checkOutput("async_rst_level", 32'(level), 32'(0));
                checkOutput("async_rst_press", 32'(press), 32'(0));
                checkOutput("async_rst_release", 32'(rel), 32'(0));
            end else begin
                Reset_n = rn;
            end
            @(posedge Clk190);
            #1;
            modelStep(d, r, rn);
            checkOutput("level", 32'(level), 32'(mLevel));
            checkOutput("press", 32'(press), 32'(expPress));
            checkOutput("release", 32'(rel), 32'(expRel));
            checkOutput("press_release_overlap", 32'(press & rel), 32'(0));
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (press[ch] === 1'b1) begin
                    pressSeen[ch]++;
                    if (firstPress[ch] < 0) firstPress[ch] = phaseEdge;
                end
                if (rel[ch] === 1'b1) relSeen[ch]++;
            end
            if (press === '1) allPress++;
            if (rel === '1) allRel++;
            phaseEdge++;
            cycle++;
        end
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_level", 32'(level), 32'(0));
        checkOutput("reset_press", 32'(press), 32'(0));
        checkOutput("reset_release", 32'(rel), 32'(0));
        applyStimulus('0, 1'b0, 1'b0, 3);
        applyStimulus('0, 1'b0, 1'b1, 4);

        $display("[TB] clean press on channel 0");
        clearStats();
        applyStimulus(5'b00001, 1'b0, 1'b1, 20);
        applyStimulus(5'b00000, 1'b0, 1'b1, 10);
        checkOutput("clean_latency", 32'(firstPress[0]), 32'(LATENCY));
        checkOutput("clean_press_count", 32'(pressSeen[0]), 32'(1));
        checkOutput("clean_release_count", 32'(relSeen[0]), 32'(1));
        checkOutput("clean_other_channels", 32'(pressSeen[1] + pressSeen[2] + pressSeen[3] + pressSeen[4]), 32'(0));

        $display("[TB] bounce on channel 1");
        clearStats();
        applyStimulus(5'b00010, 1'b0, 1'b1, 3);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1);
        applyStimulus(5'b00010, 1'b0, 1'b1, 10);
        applyStimulus(5'b00000, 1'b0, 1'b1, 12);
        checkOutput("bounce_latency", 32'(firstPress[1]), 32'(4 + LATENCY));
        checkOutput("bounce_press_count", 32'(pressSeen[1]), 32'(1));

        $display("[TB] hold with repeat on channel 2");
        clearStats();
        applyStimulus(5'b00100, 1'b1, 1'b1, 200);
        applyStimulus(5'b00000, 1'b1, 1'b1, 12);
        checkOutput("repeat_first_press", 32'(firstPress[2]), 32'(LATENCY));
        checkOutput("repeat_press_count", 32'(pressSeen[2]), 32'(7));
        checkOutput("repeat_release_count", 32'(relSeen[2]), 32'(1));

        $display("[TB] hold without repeat on channel 2");
        clearStats();
        applyStimulus(5'b00100, 1'b0, 1'b1, 200);
        applyStimulus(5'b00000, 1'b0, 1'b1, 12);
        checkOutput("norepeat_press_count", 32'(pressSeen[2]), 32'(1));
        checkOutput("norepeat_release_count", 32'(relSeen[2]), 32'(1));

        $display("[TB] simultaneous press and release on all channels");
        clearStats();
        applyStimulus(5'b11111, 1'b0, 1'b1, 10);
        applyStimulus(5'b00000, 1'b0, 1'b1, 10);
        checkOutput("simul_all_press", 32'(allPress), 32'(1));
        checkOutput("simul_all_release", 32'(allRel), 32'(1));

        $display("[TB] reset while counting toward high on channel 3");
        clearStats();
        applyStimulus(5'b01000, 1'b0, 1'b1, 4);
        applyStimulus(5'b01000, 1'b0, 1'b0, 2);
        checkOutput("rst_pend_no_press", 32'(pressSeen[3]), 32'(0));
        clearStats();
        applyStimulus(5'b01000, 1'b0, 1'b1, 15);
        applyStimulus(5'b00000, 1'b0, 1'b1, 12);
        checkOutput("rst_pend_fresh_latency", 32'(firstPress[3]), 32'(LATENCY + 1));
        checkOutput("rst_pend_press_count", 32'(pressSeen[3]), 32'(1));
        checkOutput("rst_pend_release_count", 32'(relSeen[3]), 32'(1));

        $display("[TB] reset while repeating on channel 4");
        clearStats();
        applyStimulus(5'b10000, 1'b1, 1'b1, 110);
        checkOutput("rst_rpt_pre_presses", 32'(pressSeen[4]), 32'(2));
        applyStimulus(5'b10000, 1'b1, 1'b0, 2);
        clearStats();
        applyStimulus(5'b10000, 1'b1, 1'b1, 20);
        checkOutput("rst_rpt_fresh_latency", 32'(firstPress[4]), 32'(LATENCY + 1));
        checkOutput("rst_rpt_press_count", 32'(pressSeen[4]), 32'(1));
        applyStimulus(5'b00000, 1'b1, 1'b1, 12);

        $display("[TB] random bouncing buttons");
        target = '0;
        rr     = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) bounceLeft[ch] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 149) == 0) begin
                    target[ch]     = ~target[ch];
                    bounceLeft[ch] = int'($urandom_range(0, 6));
                end
                if (bounceLeft[ch] > 0) begin
                    rd[ch] = 1'($urandom_range(0, 1));
                    bounceLeft[ch]--;
                end else begin
                    rd[ch] = target[ch];
                end
            end
            if ($urandom_range(0, 299) == 0) rr = ~rr;
            if ($urandom_range(0, 699) == 0) applyStimulus(rd, rr, 1'b0, int'($urandom_range(1, 3)));
            else applyStimulus(rd, rr, 1'b1, 1);
        end
        applyStimulus('0, 1'b0, 1'b1, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/multi_channel_debouncer.md
# multi_channel_debouncer

Parametrised N-channel push-button conditioner sitting between the board buttons and the user logic in the 190 Hz slow-clock domain. Each channel synchronises its raw input, qualifies it with a stability counter, and exports a clean level, a one-cycle press pulse, and a one-cycle release pulse. An optional hold-to-repeat mode re-issues press pulses while a button stays down, for counter and menu style inputs.

## Interface
- NUM_CH, 5: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- STABLE_CNT, 4: consecutive cycles of a changed synchronised input needed to accept the change (≥1).
- REPEAT_DELAY, 95: cycles from the initial press pulse to the first repeat pulse (≥2; ≈0.5 s at 190 Hz).
- REPEAT_RATE, 19: cycles between subsequent repeat pulses (≥1; ≈10 Hz).
- Clk190  input  1  slow system clock; all flops on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- din  input  NUM_CH  raw, asynchronous, bouncing button inputs.
- rep_en  input  1  global hold-to-repeat enable, synchronous to Clk190.
- level  output  NUM_CH  debounced button state.
- press  output  NUM_CH  one-cycle pulse on accepted 0→1 edge and on each repeat.
- release  output  NUM_CH  one-cycle pulse on accepted 1→0 edge.

## Operation
- Per channel: sync chain (sync), then a five-state FSM with a shared counter cnt.
- States: IDLE (level=0, stable), PEND_H (counting toward high), HELD_DLY (level=1, waiting for the first repeat), HELD_RPT (level=1, repeating), PEND_L (counting toward low).
- IDLE: sync=1 → PEND_H, cnt=1. If STABLE_CNT=1, go straight to HELD_DLY and assert press.
- PEND_H: sync=0 → IDLE, cnt=0 (glitch rejected). sync=1 and cnt=STABLE_CNT-1 → HELD_DLY, level<=1, press<=1, cnt=0. Otherwise cnt++.
- HELD_DLY/HELD_RPT: sync=0 → PEND_L, cnt=1. Otherwise, if rep_en=1, cnt++. At cnt=REPEAT_DELAY-1 (HELD_DLY) or REPEAT_RATE-1 (HELD_RPT), press<=1, cnt=0, go to HELD_RPT. If rep_en=0, cnt=0 and the state goes to HELD_DLY.
- PEND_L: sync=1 → HELD_DLY, cnt=0 (glitch rejected, and the repeat timer restarts). sync=0 and cnt=STABLE_CNT-1 → IDLE, level<=0, release<=1, cnt=0. Otherwise cnt++.
- Counter width: clog2 of max(STABLE_CNT, REPEAT_DELAY, REPEAT_RATE)+1. Counter never wraps; it is always cleared at its terminal value.
- Channels are fully independent. Simultaneous events on any subset of channels produce pulses in the same cycle.

## Timing
- Reset (async assert, Reset_n=0): sync chain, cnt, level, press and release all 0, FSM=IDLE, immediately without a clock edge.
- Deassertion is synchronous to the next Clk190 edge via the usual reset-release flop. Outputs hold 0 until then.
- Latency: din stable from before edge E0 → level/press (or release) registered at edge E0+SYNC_STAGES+STABLE_CNT-1. With the defaults this is the 5th edge.
- press and release are high for exactly one cycle per event and coincide with the level transition cycle.
- First repeat press: REPEAT_DELAY cycles after the initial press. Subsequent repeat presses: every REPEAT_RATE cycles.
- press and release are never high together on one channel.
- din held high through reset release: treated as a fresh press, with one press pulse after the full latency.
- Reset mid-count: the count is lost and no pulse is emitted.
- rep_en changing mid-hold only affects later cycles. Re-enabling restarts REPEAT_DELAY.

## Structure
- Package debounce_pkg holds:
  - the state enum (IDLE, PEND_H, HELD_DLY, HELD_RPT, PEND_L, 3-bit encoding);
  - a cnt_width(a,b,c) function;
  - parameter legality checks.
- Sub-module debounce_channel: sync chain, FSM and counter for one channel.
- The top instantiates debounce_channel NUM_CH times in a generate loop. rep_en is fanned out to every channel.

## Test plan
- Clean press, ch0 din 0→1 held 20 cycles (defaults) → level[0]=1 and press[0]=1 at the 5th edge only, then press low; other channels stay 0.
- Bounce, ch1 high for 3 cycles, low 1 cycle, high 10 cycles → no press during the first burst; a single press after 4 stable synchronised cycles of the final high.
- Repeat, rep_en=1, ch2 held 200 cycles → press at t=5, then at t=5+95=100, 119, 138, 157, 176, 195; one release after din falls.
- Repeat disabled, rep_en=0, same hold → exactly one press and one release.
- Simultaneous, din=5'b11111 then 5'b00000 → all five press bits in the same cycle, later all five release bits in the same cycle.
- Reset mid-operation, Reset_n low during PEND_H and during HELD_RPT → all outputs 0 immediately, no pulse; din still high after release → one fresh press after full latency.
